// File: rtl/series_ctrl_pkg.sv
// Shared types and defaults for the series-evaluation controller.
package series_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAITREL,
      LOAD,
      ADD,
      MULX,
      MULC,
      DONE
   } state_t;

   localparam int unsigned MAX_TERMS_DEF = 16;
   localparam int unsigned CNT_W_DEF     = 5;

endpackage

// File: rtl/series_controller_term_counter.sv
// Term counter: synchronous clear/increment with a terminal flag at MAX_TERMS.
module term_counter
   import series_ctrl_pkg::*;
#(
   parameter int unsigned MAX_TERMS = MAX_TERMS_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == CNT_W'(MAX_TERMS));

endmodule

// File: rtl/series_controller.sv
// Control FSM for the series-evaluation datapath (LOAD, then ADD/MULX/MULC per term).
// Optional limit_hit status port enabled by defining SERIES_LIMIT_FLAG_EN.
module series_controller
   import series_ctrl_pkg::*;
#(
   parameter int unsigned MAX_TERMS = MAX_TERMS_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic gt,
   output logic ldx,
   output logic ldy,
   output logic ldr,
   output logic ldt,
   output logic ldadr,
   output logic initr,
   output logic initt,
   output logic zadr,
   output logic xmult,
   output logic coeffmult,
   output logic ready,
   output logic busy,
   output logic done
`ifdef SERIES_LIMIT_FLAG_EN
  ,output logic limit_hit
`endif
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count;
   logic             at_max;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             add_exit;

   term_counter #(
      .MAX_TERMS (MAX_TERMS),
      .CNT_W     (CNT_W)
   ) u_term_counter (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .count  (count),
      .at_max (at_max)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ADD terminates on threshold reached or term budget exhausted
   assign add_exit = gt || at_max;
   assign cnt_clr  = (state_q == LOAD);
   assign cnt_inc  = (state_q == ADD) && !add_exit;

   always_comb begin
      state_d   = state_q;
      ldx       = 1'b0;
      ldy       = 1'b0;
      ldr       = 1'b0;
      ldt       = 1'b0;
      ldadr     = 1'b0;
      initr     = 1'b0;
      initt     = 1'b0;
      zadr      = 1'b0;
      xmult     = 1'b0;
      coeffmult = 1'b0;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) state_d = WAITREL;
         end
         WAITREL: begin
            busy = 1'b1;
            if (!start) state_d = LOAD;
         end
         LOAD: begin
            busy    = 1'b1;
            ldx     = 1'b1;
            ldy     = 1'b1;
            initr   = 1'b1;
            initt   = 1'b1;
            zadr    = 1'b1;
            state_d = ADD;
         end
         ADD: begin
            busy = 1'b1;
            if (add_exit) begin
               state_d = DONE;
            end else begin
               ldr     = 1'b1;
               state_d = MULX;
            end
         end
         MULX: begin
            busy    = 1'b1;
            xmult   = 1'b1;
            ldt     = 1'b1;
            state_d = MULC;
         end
         MULC: begin
            busy      = 1'b1;
            coeffmult = 1'b1;
            ldt       = 1'b1;
            ldadr     = 1'b1;
            state_d   = ADD;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SERIES_LIMIT_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst || state_q == LOAD) begin
         limit_hit <= 1'b0;
      end else if (state_q == ADD && at_max && !gt) begin
         limit_hit <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_series_controller.sv
// Randomized self-checking bench for series_controller against a per-run behavioural model.
// Define SERIES_LIMIT_FLAG_EN to also check the limit_hit port.
module tb_series_controller;

   localparam int MAX_TERMS = 16;

   logic clk = 1'b0;
   logic rst, start, gt;
   logic ldx, ldy, ldr, ldt, ldadr, initr, initt, zadr, xmult, coeffmult;
   logic ready, busy, done;
`ifdef SERIES_LIMIT_FLAG_EN
   logic limit_hit;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   series_controller #(.MAX_TERMS(16), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .gt        (gt),
      .ldx       (ldx),
      .ldy       (ldy),
      .ldr       (ldr),
      .ldt       (ldt),
      .ldadr     (ldadr),
      .initr     (initr),
      .initt     (initt),
      .zadr      (zadr),
      .xmult     (xmult),
      .coeffmult (coeffmult),
      .ready     (ready),
      .busy      (busy),
      .done      (done)
`ifdef SERIES_LIMIT_FLAG_EN
     ,.limit_hit (limit_hit)
`endif
   );

   always @(negedge clk) begin
      assert (!(xmult && coeffmult)) else $error("xmult and coeffmult both high");
   end

   function automatic logic [9:0] strobes();
      return {ldx, ldy, ldr, ldt, ldadr, initr, initt, zadr, xmult, coeffmult};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: a run evaluates min(gt_after, MAX_TERMS) terms; gt_after is the
   // number of completed terms after which the datapath reports gt=1.
   task automatic run(input int gt_after, input int hold, input int abort_at_mulx);
      int n_terms, t, n_ldr, n_ldadr, n_ldt, t_done, both;
      bit seen_load, overlap_bad;
      n_terms = (gt_after < MAX_TERMS) ? gt_after : MAX_TERMS;
      gt = (gt_after == 0);
      @(negedge clk);
      check("ready_idle", ready, 1);
      start = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("waitrel_busy", busy, 1);
         check("waitrel_strobes", strobes(), 0);
      end
      start = 1'b0;
      seen_load = 0;
      for (int i = 0; i < 4 && !seen_load; i++) begin
         @(negedge clk);
         if (ldx) seen_load = 1;
      end
      check("load_seen", seen_load, 1);
      check("load_strobes", strobes(), 10'b1100011100);
      n_ldr = 0; n_ldadr = 0; n_ldt = 0; t_done = -1; both = 0; overlap_bad = 0;
      for (t = 1; t < 200 && t_done < 0; t++) begin
         @(negedge clk);
         if (abort_at_mulx && xmult) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_ready", ready, 1);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_strobes", strobes(), 0);
`ifdef SERIES_LIMIT_FLAG_EN
            check("abort_limit", limit_hit, 0);
`endif
            gt = 1'b0;
            return;
         end
         if (ldx || ldy || initr || initt || zadr) overlap_bad = 1;
         if (xmult && coeffmult) both++;
         n_ldr   += int'(ldr);
         n_ldt   += int'(ldt);
         if (ldadr) begin
            n_ldadr++;
            if (n_ldadr >= gt_after) gt = 1'b1;
         end
         if (done) t_done = t;
      end
      check("done_latency", t_done, 2 + 3 * n_terms);
      check("ldr_pulses", n_ldr, n_terms);
      check("ldadr_pulses", n_ldadr, n_terms);
      check("ldt_pulses", n_ldt, 2 * n_terms);
      check("no_reload", overlap_bad, 0);
      check("sel_exclusive", both, 0);
`ifdef SERIES_LIMIT_FLAG_EN
      check("limit_hit", limit_hit, (gt_after > MAX_TERMS) ? 1 : 0);
`endif
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("ready_after", ready, 1);
`ifdef SERIES_LIMIT_FLAG_EN
      check("limit_held", limit_hit, (gt_after > MAX_TERMS) ? 1 : 0);
`endif
      gt = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; gt = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_strobes", strobes(), 0);
`ifdef SERIES_LIMIT_FLAG_EN
      check("rst_limit", limit_hit, 0);
`endif
      run(999, 2, 0);
      run(0, 1, 0);
      run(3, 1, 0);
      run(16, 1, 0);
      run(999, 1, 1);
      run(999, 2, 0);
      run(5, 100, 0);
      for (int k = 0; k < 8; k++) begin
         run($urandom_range(0, 20), $urandom_range(1, 4), 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
